st2bus_pack: RTL and testbench
==============================

# st2bus_pack

Packs a byte-wide Avalon-ST packet stream, such as decoded turbo output, into 534-bit bus words for return over the host bus. It is the return-path counterpart of the bus-to-stream unpacking on the turbo input side. It sits after the output stream mux and any clock-domain crossing, so it runs entirely in clk_bus. A 2-entry output FIFO decouples stream acceptance from bus backpressure.

## Interface
- BUS, 534, bus word width (512 payload + 22 tag)
- ST, 8, stream data width (one byte per beat)
- clk_bus  in  1  bus clock
- rst_n  in  1  reset, synchronous, active-low; clock clk_bus
- st_data  in  ST  stream byte
- st_valid  in  1  beat valid
- st_sop  in  1  first beat of packet
- st_eop  in  1  last beat of packet
- st_ready  out  1  block can accept a beat this cycle
- bus_data  out  BUS  head-of-FIFO bus word
- bus_en  out  1  word transferred this cycle
- bus_ready  in  1  sink can take a word this cycle
- err_cnt  out  8  saturating protocol-error count

## Operation
- Bus word layout:
  - [511:0] payload; byte k of the word is at [8k+7:8k]; unused lanes are 0.
  - [518:512] valid byte count, 1..64.
  - [519] sop word.
  - [520] eop word.
  - [532:521] 12-bit packet sequence number.
  - [533] parity bit (see Configuration).
- A beat is accepted when st_valid and st_ready are both 1.
- Packer FSM:
  - IDLE: an accepted beat with st_sop=1 writes lane 0, sets lane count to 1, sets the sop-pending flag, and moves to INPKT. If st_eop=1 on the same beat, the packer pushes a 1-byte word (sop=1, eop=1) and stays in IDLE.
  - IDLE: an accepted beat with st_sop=0 is dropped and err_cnt increments.
  - INPKT: each accepted beat writes the next lane.
  - The packer pushes a word to the FIFO when lane 64 is filled or st_eop=1.
  - The sop bit is set only on the first word of a packet. The eop bit is set only on the word that contains st_eop.
  - After an eop push, the FSM returns to IDLE and seq increments (4095 wraps to 0).
  - INPKT: st_sop=1 discards the partial word, increments err_cnt, and restarts the packet with this beat as lane 0. seq does not increment. Words of the aborted packet already pushed remain in the FIFO.
  - After each push, the accumulator is cleared to 0 and the lane count is cleared to 0.
- FIFO:
  - 2 entries.
  - st_ready = !full, based on registered occupancy. No beat is accepted when the FIFO is full, even if a pop occurs in the same cycle.
  - bus_en = !empty && bus_ready, combinational.
  - bus_data = head entry. It is 0 when the FIFO is empty.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- err_cnt saturates at 255.

## Timing
- Reset values:
  - st_ready=0 during reset, 1 on the first cycle after reset.
  - bus_en=0, bus_data=0, err_cnt=0.
  - FSM=IDLE, seq=0, FIFO empty, accumulator=0.
- Latency: when the word-completing beat is accepted in cycle N, the word is at the FIFO head and bus_en can assert in cycle N+1 if the FIFO was empty.
- Throughput:
  - One byte per cycle on the stream side.
  - One word per cycle on the bus side while bus_ready=1.
  - The bus-side rate is never limited by packing.
- Backpressure: with bus_ready=0 and a stream of full words, st_ready drops the cycle after the second push.
- Reset mid-operation: partial words and FIFO contents are discarded, with no partial output.

## Configuration
- ST2BUS_PARITY_EN defined: bit [533] = XOR of payload bits [511:0], computed at push time.
- ST2BUS_PARITY_EN undefined: bit [533] = 0 and no parity logic is synthesized.

## Test plan
- 128-byte packet with bytes 0x00..0x7F and bus_ready=1 -> 2 words:
  - Word 1: cnt=64, sop=1, eop=0, seq=0, payload bytes 0x00..0x3F.
  - Word 2: cnt=64, sop=0, eop=1, seq=0, payload bytes 0x40..0x7F.
- 70-byte packet -> word 1 has cnt=64; word 2 has cnt=6, lanes 6..63 are 0, eop=1. A single-beat packet (sop=eop=1, data 0xA5) -> one word with cnt=1, sop=1, eop=1, [7:0]=0xA5.
- bus_ready=0, then three 64-byte packets -> st_ready=0 after 2 words are pushed. Raising bus_ready releases words in order with seq 0,1,2 and no byte loss.
- Beat without sop in IDLE, then a sop at byte 10 of a packet -> err_cnt=2, and the restarted packet emits with an unchanged seq.
- 4097 single-byte packets -> seq runs 0..4095, then 0. Reset asserted mid-packet -> all outputs return to their reset values, and the next packet starts with seq=0.
- With ST2BUS_PARITY_EN defined, a payload of all 0xFF except one byte of 0xFE -> bit [533]=1.

Source files
------------

// File: rtl/st2bus_pack.sv
// st2bus_pack: packs a byte-wide Avalon-ST packet stream into 534-bit bus words behind a
// 2-entry output FIFO. Optional macro ST2BUS_PARITY_EN fills bit [533] with payload parity.
package st2bus_pack_pkg;
  localparam int unsigned BUS    = 534;
  localparam int unsigned ST     = 8;
  localparam int unsigned PAY_W  = 512;
  localparam int unsigned LANES  = PAY_W / ST;
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned SEQ_W  = 12;
  localparam int unsigned ERR_W  = 8;

  typedef struct packed {
    logic             parity;
    logic [SEQ_W-1:0] seq;
    logic             eop;
    logic             sop;
    logic [CNT_W-1:0] cnt;
    logic [PAY_W-1:0] payload;
  } bus_word_t;
endpackage

module st2bus_pack
  import st2bus_pack_pkg::*;
(
  input  logic             clk_bus,
  input  logic             rst_n,
  input  logic [ST-1:0]    st_data,
  input  logic             st_valid,
  input  logic             st_sop,
  input  logic             st_eop,
  output logic             st_ready,
  output logic [BUS-1:0]   bus_data,
  output logic             bus_en,
  input  logic             bus_ready,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {S_IDLE, S_INPKT} state_t;

  state_t            state_q, state_d;
  logic [PAY_W-1:0]  acc_q, acc_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              sop_pend_q, sop_pend_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              st_ready_q, st_ready_d;
  bus_word_t         fifo_mem_q [2];
  bus_word_t         fifo_mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              accept_c, take_c, err_inc_c, push_c, pop_c;
  bus_word_t         word_c;
  logic [PAY_W-1:0]  base_acc_c, filled_acc_c;
  logic [LANE_W-1:0] base_lane_c;
  logic              base_sop_c;

  assign accept_c = st_valid && st_ready_q;
  assign st_ready = st_ready_q;
  assign err_cnt  = err_q;
  assign bus_en   = (fifo_cnt_q != 2'd0) && bus_ready;
  assign pop_c    = bus_en;
  assign bus_data = (fifo_cnt_q != 2'd0) ? fifo_mem_q[rd_ptr_q] : '0;

  // Packer: a sop beat always restarts at lane 0, discarding any partial word.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    lane_d     = lane_q;
    sop_pend_d = sop_pend_q;
    seq_d      = seq_q;
    err_d      = err_q;
    take_c     = 1'b0;
    err_inc_c  = 1'b0;
    push_c     = 1'b0;
    word_c     = '0;
    base_acc_c  = acc_q;
    base_lane_c = lane_q;
    base_sop_c  = sop_pend_q;

    if (accept_c) begin
      if (st_sop) begin
        take_c      = 1'b1;
        err_inc_c   = (state_q == S_INPKT);
        base_acc_c  = '0;
        base_lane_c = '0;
        base_sop_c  = 1'b1;
      end else if (state_q == S_INPKT) begin
        take_c = 1'b1;
      end else begin
        err_inc_c = 1'b1;
      end
    end

    filled_acc_c = base_acc_c;
    filled_acc_c[{base_lane_c, 3'b000} +: ST] = st_data;

    if (take_c) begin
      if (st_eop || (base_lane_c == LANE_W'(LANES - 1))) begin
        push_c         = 1'b1;
        word_c.payload = filled_acc_c;
        word_c.cnt     = CNT_W'(base_lane_c) + CNT_W'(1);
        word_c.sop     = base_sop_c;
        word_c.eop     = st_eop;
        word_c.seq     = seq_q;
`ifdef ST2BUS_PARITY_EN
        word_c.parity  = ^filled_acc_c;
`else
        word_c.parity  = 1'b0;
`endif
        acc_d      = '0;
        lane_d     = '0;
        sop_pend_d = 1'b0;
        if (st_eop) begin
          state_d = S_IDLE;
          seq_d   = seq_q + SEQ_W'(1);
        end else begin
          state_d = S_INPKT;
        end
      end else begin
        acc_d      = filled_acc_c;
        lane_d     = base_lane_c + LANE_W'(1);
        sop_pend_d = base_sop_c;
        state_d    = S_INPKT;
      end
    end

    if (err_inc_c && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // Output FIFO; ready is derived from the next occupancy so it is a clean flop.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_c) begin
      fifo_mem_d[wr_ptr_q] = word_c;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop_c) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push_c, pop_c})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    st_ready_d = (fifo_cnt_d != 2'd2);
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      lane_q     <= '0;
      sop_pend_q <= 1'b0;
      seq_q      <= '0;
      err_q      <= '0;
      st_ready_q <= 1'b0;
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      sop_pend_q <= sop_pend_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
      st_ready_q <= st_ready_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_st2bus_pack.sv
// Bench for st2bus_pack: directed packets plus random traffic, checked every cycle against a
// byte-queue packet model. Honours ST2BUS_PARITY_EN when expecting bit [533].
module tb_st2bus_pack;
  localparam int unsigned BW = 534;

  logic          clk_bus = 1'b0;
  logic          rst_n;
  logic [7:0]    st_data;
  logic          st_valid;
  logic          st_sop;
  logic          st_eop;
  logic          st_ready;
  logic [BW-1:0] bus_data;
  logic          bus_en;
  logic          bus_ready;
  logic [7:0]    err_cnt;

  st2bus_pack dut (
    .clk_bus  (clk_bus),
    .rst_n    (rst_n),
    .st_data  (st_data),
    .st_valid (st_valid),
    .st_sop   (st_sop),
    .st_eop   (st_eop),
    .st_ready (st_ready),
    .bus_data (bus_data),
    .bus_en   (bus_en),
    .bus_ready(bus_ready),
    .err_cnt  (err_cnt)
  );

  always #5 clk_bus = ~clk_bus;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef logic [7:0] byte_q_t[$];

  function automatic logic [BW-1:0] mk_word(input byte_q_t b, input bit s, input bit e, input int sq);
    logic [BW-1:0] w;
    w = '0;
    foreach (b[i]) w[8*i +: 8] = b[i];
    w[518:512] = 7'(b.size());
    w[519]     = s;
    w[520]     = e;
    w[532:521] = 12'(sq);
`ifdef ST2BUS_PARITY_EN
    w[533]     = ^w[511:0];
`endif
    return w;
  endfunction

  // Packet-level reference: bytes gather in a queue, a word is emitted at 64 bytes or eop.
  logic [BW-1:0] exp_q[$];
  byte_q_t       cur;
  bit            m_sop, m_inpkt, ready_ok, exp_ready, m_acc, m_pop;
  int            m_seq, m_err, occ;

  always @(negedge clk_bus) begin
    if (!rst_n) begin
      exp_q.delete();
      cur.delete();
      m_sop = 0; m_inpkt = 0; m_seq = 0; m_err = 0; occ = 0; ready_ok = 0;
    end else begin
      exp_ready = ready_ok && (occ < 2);
      check_eq("st_ready", BW'(st_ready), BW'(exp_ready));
      check_eq("bus_en", BW'(bus_en), BW'((occ > 0) && bus_ready));
      check_eq("err_cnt", BW'(err_cnt), BW'(m_err));
      if (occ > 0) check_eq("bus_data", bus_data, exp_q[0]);
      else         check_eq("bus_data_idle", bus_data, '0);
      m_pop = (occ > 0) && bus_ready;
      m_acc = st_valid && exp_ready;
      if (m_pop) begin
        void'(exp_q.pop_front());
        occ--;
      end
      if (m_acc) begin
        if (st_sop) begin
          if (m_inpkt && m_err < 255) m_err++;
          cur.delete();
          cur.push_back(st_data);
          m_sop = 1;
          m_inpkt = 1;
        end else if (!m_inpkt) begin
          if (m_err < 255) m_err++;
        end else begin
          cur.push_back(st_data);
        end
        if (m_inpkt && (st_eop || cur.size() == 64)) begin
          exp_q.push_back(mk_word(cur, m_sop, st_eop, m_seq));
          occ++;
          cur.delete();
          m_sop = 0;
          if (st_eop) begin
            m_inpkt = 0;
            m_seq = (m_seq + 1) % 4096;
          end
        end
      end
      ready_ok = 1;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int n;
    bit done;
    n = 0;
    done = 0;
    st_valid = 1'b1; st_data = d; st_sop = s; st_eop = e;
    while (!done && n < 2000) begin
      @(negedge clk_bus);
      done = st_ready;
      n++;
      @(posedge clk_bus);
      #1;
    end
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    if (!done) check_eq("beat_timeout", BW'(done), BW'(1));
  endtask

  task automatic send_pkt(input int len, input int start);
    for (int i = 0; i < len; i++) send_beat(8'(start + i), i == 0, i == len - 1);
  endtask

  task automatic do_reset();
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = '0;
    bus_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_bus);
    #1;
    check_eq("rst_st_ready", BW'(st_ready), '0);
    check_eq("rst_bus_en", BW'(bus_en), '0);
    check_eq("rst_bus_data", bus_data, '0);
    check_eq("rst_err_cnt", BW'(err_cnt), '0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus_ready = 1'b1;
    while (occ != 0 && n < 500) begin
      @(posedge clk_bus);
      n++;
    end
    #1;
    check_eq("drained", BW'(occ), '0);
  endtask

  bit rnd_done;
  int len;
  bit s_rand;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = '0; bus_ready = 1'b0;
    do_reset();

    // Two full words, a 64+6 split, and a single-beat packet.
    send_pkt(128, 0);
    send_pkt(70, 8'h10);
    send_beat(8'hA5, 1'b1, 1'b1);
    drain();

    // Backpressure: three 64-byte packets into a stalled sink.
    bus_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send_pkt(64, k * 64);
      end
      begin
        repeat (200) @(posedge clk_bus);
        #1;
        check_eq("bp_stall", BW'(st_ready), '0);
        bus_ready = 1'b1;
      end
    join
    drain();

    // Stray beat in idle, then a restart at byte 10.
    do_reset();
    send_beat(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) send_beat(8'(i), (i == 0) || (i == 10), i == 29);
    drain();
    repeat (2) @(posedge clk_bus);
    #1;
    check_eq("err_two", BW'(err_cnt), BW'(2));

    // Sequence wrap.
    for (int i = 0; i < 4097; i++) send_beat(8'(i), 1'b1, 1'b1);
    drain();

    // Parity word: 63 x 0xFF then 0xFE.
    for (int i = 0; i < 64; i++) send_beat((i == 63) ? 8'hFE : 8'hFF, i == 0, i == 63);
`ifdef ST2BUS_PARITY_EN
    check_eq("parity_bit", BW'(bus_data[533]), BW'(1));
`else
    check_eq("parity_bit", BW'(bus_data[533]), '0);
`endif
    check_eq("parity_cnt", BW'(bus_data[518:512]), BW'(64));
    drain();

    // Reset in the middle of a packet, then a fresh packet must carry seq 0.
    bus_ready = 1'b0;
    for (int i = 0; i < 100; i++) send_beat(8'(i), i == 0, 1'b0);
    do_reset();
    send_pkt(5, 8'h40);
    check_eq("post_rst_seq", BW'(bus_data[532:521]), '0);
    check_eq("post_rst_cnt", BW'(bus_data[518:512]), BW'(5));
    drain();

    // Random traffic with random sink stalls and injected protocol errors.
    rnd_done = 0;
    fork
      begin
        for (int p = 0; p < 60; p++) begin
          len = $urandom_range(1, 150);
          if ($urandom_range(0, 19) == 0) send_beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
          for (int i = 0; i < len; i++) begin
            s_rand = (i == 0) || ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk_bus);
              #1;
            end
            send_beat(8'($urandom), s_rand, i == len - 1);
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_bus);
          #1;
          bus_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
